// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the memory port arbiter.
//   state_t : access sequencer states
//   owner_t : which requester currently owns the memory port
package mem_arb_pkg;

    localparam int DEF_MEM_LATENCY = 6;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_WORD_W      = 16;
    localparam int DEF_LINE_W      = 64;

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/mem_latency_counter.sv
// mem_latency_counter: down-counter timing one memory access.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : preload the counter with MEM_LATENCY
//   dec          : decrement by one (saturates at zero)
//   zero         : counter currently reads zero
module mem_latency_counter #(
    parameter int MEM_LATENCY = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= CNT_W'(MEM_LATENCY);
        else if (dec && count != '0)
            count <= count - CNT_W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency line-wide memory port between
// an instruction-fetch requester (line reads) and a data requester (line
// reads, single-word writes).
//   clk, reset_n                : clock, synchronous active-low reset
//   i_req/i_addr                : fetch request, word address
//   i_done/i_rdata              : fetch completion pulse, returned line
//   d_req/d_we/d_addr/d_wdata   : data request, write enable, address, word
//   d_done/d_rdata              : data completion pulse, returned line
//   mem_read/mem_write          : memory strobes
//   mem_addr/mem_wdata          : latched address / write word to memory
//   mem_rdata                   : line returned by memory
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int LINE_W      = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata
);

    state_t            state, state_nxt;
    owner_t            owner, last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              we_q;
    logic              grant_i, grant_d;
    logic              cnt_zero;

    // Grants are only considered in IDLE. On a tie the requester that did
    // not win last time goes first, so continuous contention alternates.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_req && d_req) begin
                if (last_grant == OWN_I) grant_d = 1'b1;
                else                     grant_i = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    mem_latency_counter #(.MEM_LATENCY(MEM_LATENCY)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (grant_i | grant_d),
        .dec     (state == ACCESS),
        .zero    (cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic. ACCESS runs while the counter walks MEM_LATENCY..0,
    // i.e. MEM_LATENCY+1 cycles; RELEASE is the forced strobe-low gap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_i || grant_d) state_nxt = ACCESS;
            ACCESS:  if (cnt_zero)           state_nxt = RELEASE;
            RELEASE:                         state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Request latch, line capture and fairness bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner      <= OWN_NONE;
            last_grant <= OWN_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (grant_i) begin
                owner   <= OWN_I;
                addr_q  <= i_addr;
                wdata_q <= '0;
                we_q    <= 1'b0;
            end else if (grant_d) begin
                owner   <= OWN_D;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                we_q    <= d_we;
            end
            if (state == ACCESS && cnt_zero && !we_q) begin
                if (owner == OWN_I)      i_rdata <= mem_rdata;
                else if (owner == OWN_D) d_rdata <= mem_rdata;
            end
            if (state == RELEASE) begin
                last_grant <= owner;
                owner      <= OWN_NONE;
            end
        end
    end

    // Outputs
    always_comb begin
        mem_read  = (state == ACCESS) && !we_q;
        mem_write = (state == ACCESS) &&  we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        i_done    = (state == RELEASE) && (owner == OWN_I);
        d_done    = (state == RELEASE) && (owner == OWN_D);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one line-wide, fixed-latency memory port between two requesters: the instruction-fetch side (line reads only) and the data side (line reads and single-word writes).
- Sits between the fetch/load-store units and the memory model.
- Sequences each access: holds the memory strobes for a fixed latency, captures the line, returns it with a one-cycle done pulse.
- Forces a one-cycle strobe release between accesses so the memory sees a fresh rising access edge.

Parameters:
MEM_LATENCY, 6, clk edges between the strobe rising and the memory data becoming valid; legal range 1..255.
ADDR_W, 16, address width in words.
WORD_W, 16, data word width.
LINE_W, 64, line width (4 words).

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
i_req  in  1  fetch line-read request, held until i_done
i_addr  in  ADDR_W  fetch word address; bits [1:0] ignored for line alignment
i_done  out  1  one-cycle pulse, i_rdata valid
i_rdata  out  LINE_W  returned line, held until the next fetch completion
d_req  in  1  data request, held until d_done
d_we  in  1  1 = word write, 0 = line read
d_addr  in  ADDR_W  data word address
d_wdata  in  WORD_W  write data
d_done  out  1  one-cycle pulse, access complete (read data valid or write committed)
d_rdata  out  LINE_W  returned line, held until the next data read completion
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  WORD_W  memory write data
mem_rdata  in  LINE_W  memory line data

Behaviour:
- Reset: synchronous, active-low on reset_n, clock clk. All outputs clear to 0, state IDLE, owner = none, last_grant = I. Reset mid-access abandons the access: no done pulse, strobes drop on the next edge.
- States: IDLE, ACCESS, RELEASE.
- IDLE, strobes low:
  - Only one request pending: grant it.
  - Both pending: grant D if last_grant = I, else grant I.
  - On grant: latch owner, address, we, wdata; load counter = MEM_LATENCY; go to ACCESS.
- ACCESS:
  - mem_read = 1 for I or D-read; mem_write = 1 for D-write. Never both.
  - mem_addr/mem_wdata come from latched values and stay stable for the whole state. Requester address changes are ignored.
  - Counter decrements each cycle. When the counter = 0: capture mem_rdata into the owner's rdata register (reads only), go to RELEASE.
  - ACCESS lasts exactly MEM_LATENCY+1 cycles.
- RELEASE:
  - Strobes low; the owner's done = 1 for exactly this cycle; last_grant = owner.
  - Go to IDLE; requests are first evaluated in the IDLE cycle after.
  - Minimum gap between accesses is therefore 2 strobe-low cycles; grant-to-grant period is MEM_LATENCY+3 cycles.
- Requester rule: drop req on the edge after done. A req still high in IDLE is treated as a new request.
- A req asserted while another access is in flight waits; it is never dropped.
- Lines are returned whole; word selection is the requester's job.
- Write commits a single word at d_addr exactly.
- done never asserts without a preceding grant.
- Fairness: with both requesters continuously pending, grants strictly alternate.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RELEASE}
  - owner enum {OWN_NONE, OWN_I, OWN_D}
  - default MEM_LATENCY, ADDR_W, WORD_W, LINE_W constants
- Sub-module mem_latency_counter: load/decrement/zero flag, width $clog2(MEM_LATENCY+1). Everything else lives in the top.

Test Plan:
- Fetch only: i_req=1, i_addr=0x0025, memory line 0x24..0x27 preloaded → mem_read high exactly 7 cycles with mem_addr=0x0025; i_done pulses once in the next cycle; i_rdata = {mem[0x27],mem[0x26],mem[0x25],mem[0x24]}.
- Write then read: d_we=1, d_addr=0x0031, d_wdata=0xBEEF; then d_we=0, d_addr=0x0030 → mem_write for 7 cycles only, d_done; the read returns d_rdata[31:16]=0xBEEF.
- Collision: i_req and d_req rise in the same IDLE cycle after reset (last_grant=I) → D served first, I granted exactly MEM_LATENCY+3 cycles after D's grant; strobes low ≥2 cycles between.
- Fairness: both reqs re-asserted continuously for 6 accesses → grant order D,I,D,I,D,I; no two done pulses in the same cycle.
- Reset mid-access: reset_n=0 for 1 cycle on the 3rd ACCESS cycle of a D write → no d_done, strobes 0 the next cycle, state IDLE; a subsequent request completes normally.
- Latency sweep: MEM_LATENCY=1 and 255 → ACCESS length 2 and 256 cycles respectively, captured data correct.
